// File: rtl/regfile_pkg.sv
// Shared widths and the writeback entry type for the 8x16 register file write path.
package regfile_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_unit_if.sv
// Producer handshakes, register file write port, decode lookups and occupancy.
interface reg_writeback_unit_if #(parameter int DEPTH = 4);
  import regfile_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              Alu_valid;
  logic [ADDR_W-1:0] Alu_address;
  logic [DATA_W-1:0] Alu_data;
  logic              Alu_ready;
  logic              Mem_valid;
  logic [ADDR_W-1:0] Mem_address;
  logic [DATA_W-1:0] Mem_data;
  logic              Mem_ready;
  logic              Wb_hold;
  logic              Reg_Write;
  logic [ADDR_W-1:0] Reg_input_address;
  logic [DATA_W-1:0] Reg_input_data;
  logic [ADDR_W-1:0] Lookup_address1;
  logic [ADDR_W-1:0] Lookup_address2;
  logic [ADDR_W-1:0] Lookup_address3;
  logic              Pending1;
  logic              Pending2;
  logic              Pending3;
  logic [DATA_W-1:0] Fwd_data1;
  logic [DATA_W-1:0] Fwd_data2;
  logic [DATA_W-1:0] Fwd_data3;
  logic [CNT_W-1:0]  Count;

  modport slave (
    input  Alu_valid, Alu_address, Alu_data, Mem_valid, Mem_address, Mem_data, Wb_hold,
           Lookup_address1, Lookup_address2, Lookup_address3,
    output Alu_ready, Mem_ready, Reg_Write, Reg_input_address, Reg_input_data,
           Pending1, Pending2, Pending3, Fwd_data1, Fwd_data2, Fwd_data3, Count
  );

  modport master (
    output Alu_valid, Alu_address, Alu_data, Mem_valid, Mem_address, Mem_data, Wb_hold,
           Lookup_address1, Lookup_address2, Lookup_address3,
    input  Alu_ready, Mem_ready, Reg_Write, Reg_input_address, Reg_input_data,
           Pending1, Pending2, Pending3, Fwd_data1, Fwd_data2, Fwd_data3, Count
  );
endinterface

// File: rtl/reg_writeback_unit_wb_fifo.sv
// In-order writeback queue; push ignored when full, pop ignored when empty.
// Exposes entries in age order (index 0 = oldest) so lookups can pick the youngest match.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output wb_entry_t        age_entry_o [DEPTH],
  output logic [DEPTH-1:0] age_vld_o
);
  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    assign age_entry_o[i] = mem_q[rd_ptr_q + PTR_W'(i)];
    assign age_vld_o[i]   = (CNT_W'(i) < count_q);
  end
endmodule

// File: rtl/reg_writeback_unit.sv
// Arbitrates ALU/load writebacks into a FIFO and drains one per cycle to the regfile (1-cycle registered write stage).
// Readies drop when full or in reset; memory wins ties; Wb_hold stalls draining without blocking pushes.
module reg_writeback_unit
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic CLK,
  input logic Reset,
  reg_writeback_unit_if.slave bus
);
  wb_entry_t         push_entry, head;
  wb_entry_t         age_entry [DEPTH];
  logic [DEPTH-1:0]  age_vld;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic              mem_xfer, alu_xfer, push, pop;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] lk_addr [3];
  logic              pend [3];
  logic [DATA_W-1:0] fwd [3];

  assign bus.Mem_ready = ~Reset & ~full;
  assign bus.Alu_ready = ~Reset & ~full & ~bus.Mem_valid;
  assign mem_xfer      = bus.Mem_valid & bus.Mem_ready;
  assign alu_xfer      = bus.Alu_valid & bus.Alu_ready;

  // r0 writes finish the handshake but are dropped here since r0 is hardwired zero.
  always_comb begin
    push_entry = '{addr: bus.Alu_address, data: bus.Alu_data};
    push       = alu_xfer & (bus.Alu_address != ZERO_REG);
    if (mem_xfer) begin
      push_entry = '{addr: bus.Mem_address, data: bus.Mem_data};
      push       = bus.Mem_address != ZERO_REG;
    end
  end

  assign pop = ~empty & ~bus.Wb_hold;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (CLK),
    .rst_i        (Reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .age_entry_o  (age_entry),
    .age_vld_o    (age_vld)
  );

  assign bus.Count = count;

  always_comb begin
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pop) begin
      wr_d    = 1'b1;
      waddr_d = head.addr;
      wdata_d = head.data;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.Reg_Write         = wr_q;
  assign bus.Reg_input_address = waddr_q;
  assign bus.Reg_input_data    = wdata_q;

  assign lk_addr[0] = bus.Lookup_address1;
  assign lk_addr[1] = bus.Lookup_address2;
  assign lk_addr[2] = bus.Lookup_address3;

  // Scan oldest to newest so later (younger) matches overwrite earlier ones.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0;
      fwd[k]  = '0;
      if (lk_addr[k] != ZERO_REG) begin
        if (wr_q && (waddr_q == lk_addr[k])) begin
          pend[k] = 1'b1;
          fwd[k]  = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (age_vld[i] && (age_entry[i].addr == lk_addr[k])) begin
            pend[k] = 1'b1;
            fwd[k]  = age_entry[i].data;
          end
        end
      end
    end
  end

  assign bus.Pending1  = pend[0];
  assign bus.Pending2  = pend[1];
  assign bus.Pending3  = pend[2];
  assign bus.Fwd_data1 = fwd[0];
  assign bus.Fwd_data2 = fwd[1];
  assign bus.Fwd_data3 = fwd[2];
endmodule
